instr_mem: RTL and testbench
============================

INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 Parameter ADDR_W, default 10, meaning log2 of memory depth in 32-bit words (depth DEPTH = 2^ADDR_W).
REQ-002 Parameter NOP_WORD, default 32'h0000_0013, meaning word returned when no valid instruction is available.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memif_addr  input  30 ([31:2])  word address from fetch stage.
REQ-006 memif_data  output  32  registered instruction word.
REQ-007 ld_start  input  1  one-cycle request to begin a program load at word 0.
REQ-008 ld_count  input  ADDR_W+1  number of words to load, sampled with ld_start.
REQ-009 ld_valid  input  1  loader byte valid.
REQ-010 ld_byte  input  8  loader byte, little-endian within each word.
REQ-011 ld_ready  output  1  block accepts ld_byte this cycle.
REQ-012 ld_busy  output  1  load in progress; fetch data is NOP_WORD.
REQ-013 ld_done  output  1  one-cycle pulse on load completion.
REQ-014 ld_err  output  1  sticky flag: last ld_start had an illegal ld_count.

Function
REQ-015 Read latency exactly 1 cycle: memif_data at edge N+1 reflects memif_addr presented in cycle N.
REQ-016 Word index = memif_addr[ADDR_W+1:2]; if any memif_addr bit above ADDR_W+1 is 1, memif_data = NOP_WORD.
REQ-017 While ld_busy = 1, memif_data = NOP_WORD regardless of memif_addr.
REQ-018 Memory is single write port, single read port; no read-modify-write, no byte enables on the write port.
REQ-019 FSM states IDLE, RECV, COMMIT, DONE; ld_busy = 1 in RECV, COMMIT, DONE.
REQ-020 IDLE: ld_start = 1 with 1 <= ld_count <= DEPTH -> RECV, waddr = 0, byte_idx = 0, words_left = ld_count, ld_err cleared.
REQ-021 IDLE: ld_start = 1 with ld_count = 0 or ld_count > DEPTH -> stay IDLE, ld_err = 1.
REQ-022 ld_ready = 1 only in RECV; a byte is accepted when ld_valid & ld_ready.
REQ-023 Accepted byte k (byte_idx k = 0..3) goes to assembled word bits [8k+7:8k]; byte_idx increments modulo 4.
REQ-024 Acceptance of byte_idx 3 -> COMMIT next cycle.
REQ-025 COMMIT: write assembled word to mem[waddr], waddr += 1, words_left -= 1; if words_left becomes 0 -> DONE else -> RECV.
REQ-026 DONE: ld_done = 1 for that single cycle, then IDLE; ld_busy falls the cycle after DONE.
REQ-027 ld_valid low in RECV stalls without losing partial bytes; no timeout.
REQ-028 ld_start while not in IDLE is ignored; bytes presented outside RECV are not accepted.
REQ-029 ld_count = DEPTH fills every word; waddr wraps to 0 only after final COMMIT and is not reused.

Reset
REQ-030 reset = 1 at a rising edge: FSM -> IDLE, waddr = 0, byte_idx = 0, words_left = 0, ld_ready = 0, ld_busy = 0, ld_done = 0, ld_err = 0, memif_data = NOP_WORD.
REQ-031 Reset mid-load aborts the load; words already committed remain in memory; a partially assembled word is discarded.
REQ-032 Memory array contents are not initialised by reset.
REQ-033 reset has priority over ld_start and any loader handshake in the same cycle.

Verification
REQ-034 Load 2 words, bytes 13 05 A0 00 93 05 10 00 with ld_valid always high -> ld_done pulses once; read addr 0 -> 32'h00A0_0513, addr 1 -> 32'h0010_0593, each 1 cycle after address.
REQ-035 ld_start with ld_count = 0, then with ld_count = DEPTH+1 -> ld_err = 1, ld_busy stays 0; next ld_start with ld_count = 1 clears ld_err.
REQ-036 Load 1 word with ld_valid toggling 1,0,0,1,1,0,1 -> word assembled from accepted bytes only, in order; ld_ready = 0 in COMMIT cycle.
REQ-037 During load, memif_addr = 0 -> memif_data = 32'h0000_0013; after ld_done, addr 0 returns loaded word.
REQ-038 memif_addr with bit 12 set (ADDR_W = 10) -> memif_data = 32'h0000_0013.
REQ-039 Load 3 words, assert reset after 6 bytes -> all outputs at reset values; word 0 retains loaded data; a new ld_start is accepted in the next cycle after reset deasserts.

Source files
------------

// File: rtl/instr_mem.sv
// Instruction memory with a byte-serial program loader.
// Fetch port: one-cycle registered read of a 32-bit word, NOP_WORD when the address is out of
// range or a load is in progress. Loader: bytes arrive little-endian, are assembled into a word
// and committed to consecutive addresses starting at word 0.
module instr_mem #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:2]       memif_addr,
    output logic [31:0]       memif_data,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_count,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err
);
    localparam int unsigned     DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] L_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] L_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRecv, StCommit, StDone} state_e;

    state_e              r_state,      w_state_d;
    logic [ADDR_W-1:0]   r_waddr,      w_waddr_d;
    logic [1:0]          r_byte_idx,   w_byte_idx_d;
    logic [ADDR_W:0]     r_words_left, w_words_left_d;
    logic [31:0]         r_word,       w_word_d;
    logic                r_err,        w_err_d;
    logic [31:0]         r_data;
    logic                w_we;
    logic                w_oor;
    logic [ADDR_W-1:0]   w_idx;

    logic [31:0] r_mem [DEPTH];

    // Any address bit above the word index makes the fetch out of range.
    assign w_oor = (memif_addr >> ADDR_W) != '0;
    assign w_idx = memif_addr[ADDR_W+1:2];

    assign ld_busy    = (r_state != StIdle);
    assign ld_err     = r_err;
    assign memif_data = r_data;

    // Loader state register; reset abandons any partially assembled word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_waddr      <= '0;
            r_byte_idx   <= '0;
            r_words_left <= '0;
            r_word       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_waddr      <= w_waddr_d;
            r_byte_idx   <= w_byte_idx_d;
            r_words_left <= w_words_left_d;
            r_word       <= w_word_d;
            r_err        <= w_err_d;
        end
    end

    // Loader next-state, byte assembly and handshake outputs.
    always_comb begin
        w_state_d      = r_state;
        w_waddr_d      = r_waddr;
        w_byte_idx_d   = r_byte_idx;
        w_words_left_d = r_words_left;
        w_word_d       = r_word;
        w_err_d        = r_err;
        w_we           = 1'b0;
        ld_ready       = 1'b0;
        ld_done        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (ld_start) begin
                    if (ld_count != '0 && ld_count <= L_DEPTH) begin
                        w_state_d      = StRecv;
                        w_waddr_d      = '0;
                        w_byte_idx_d   = '0;
                        w_words_left_d = ld_count;
                        w_err_d        = 1'b0;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            StRecv: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    w_word_d[{r_byte_idx, 3'b000} +: 8] = ld_byte;
                    w_byte_idx_d = r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
                        w_state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                w_we           = 1'b1;
                // Wraps to 0 after a full-depth load; the next load restarts at 0 anyway.
                w_waddr_d      = r_waddr + 1'b1;
                w_words_left_d = r_words_left - L_ONE;
                w_state_d      = (w_words_left_d == '0) ? StDone : StRecv;
            end
            StDone: begin
                ld_done   = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Single write port; contents are deliberately left uninitialised.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_waddr] <= r_word;
        end
    end

    // Registered fetch; keyed on next state so data is NOP for exactly the busy cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= NOP_WORD;
        end else if (w_state_d != StIdle || w_oor) begin
            r_data <= NOP_WORD;
        end else begin
            r_data <= r_mem[w_idx];
        end
    end
endmodule

// File: tb/tb_instr_mem.sv
// Directed-plus-random bench for instr_mem against a word-array reference model.
module tb_instr_mem;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CW     = ADDR_W + 1;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:2]   memif_addr;
    logic [31:0]   memif_data;
    logic          ld_start;
    logic [CW-1:0] ld_count;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_ready;
    logic          ld_busy;
    logic          ld_done;
    logic          ld_err;

    instr_mem #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .memif_addr (memif_addr),
        .memif_data (memif_data),
        .ld_start   (ld_start),
        .ld_count   (ld_count),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_ready   (ld_ready),
        .ld_busy    (ld_busy),
        .ld_done    (ld_done),
        .ld_err     (ld_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem_model [DEPTH];
    logic [7:0]  q_bytes [$];
    bit          q_pat [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:2] a);
        if ((a >> ADDR_W) != '0) return NOP;
        return mem_model[a[ADDR_W+1:2]];
    endfunction

    task automatic fill_bytes(input int n);
        q_bytes.delete();
        for (int i = 0; i < 4 * n; i++) q_bytes.push_back(8'($urandom));
    endtask

    task automatic rd(input string tag, input logic [31:2] a);
        memif_addr = a;
        tick();
        chk(tag, memif_data, model_rd(a));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, ld_ready, 1'b0);
        chk({tag, "_busy"},  ld_busy,  1'b0);
        chk({tag, "_done"},  ld_done,  1'b0);
        chk({tag, "_err"},   ld_err,   1'b0);
        chk({tag, "_data"},  memif_data, NOP);
    endtask

    // Load n words from q_bytes; q_pat (if non-empty) gives the ld_valid sequence.
    task automatic load(input int n);
        int acc = 0;
        int cyc = 0;
        int k   = 0;
        bit v;
        ld_start = 1'b1;
        ld_count = CW'(n);
        ld_valid = 1'b0;
        tick();
        ld_start = 1'b0;
        chk("start_err", ld_err, 1'b0);
        while (acc < 4 * n && cyc < 32 * n + 64) begin
            chk("recv_ready", ld_ready, 1'b1);
            chk("recv_busy", ld_busy, 1'b1);
            chk("recv_nop", memif_data, NOP);
            v = (k < q_pat.size()) ? q_pat[k] : ($urandom_range(3) != 0);
            k++;
            ld_valid   = v;
            ld_byte    = q_bytes[acc];
            // Illegal starts during a load must be ignored.
            ld_start   = 1'($urandom_range(1));
            ld_count   = '0;
            memif_addr = 30'($urandom_range(DEPTH - 1));
            tick();
            cyc++;
            if (v) begin
                acc++;
                if (acc % 4 == 0) begin
                    chk("commit_ready", ld_ready, 1'b0);
                    chk("commit_busy", ld_busy, 1'b1);
                    chk("commit_done", ld_done, 1'b0);
                    chk("commit_nop", memif_data, NOP);
                    ld_valid = 1'b1;
                    ld_byte  = 8'hEE;
                    tick();
                    cyc++;
                end
            end
        end
        chk("load_bytes", acc, 4 * n);
        ld_valid = 1'b0;
        ld_start = 1'b0;
        for (int w = 0; w < n; w++) begin
            mem_model[w] = {q_bytes[4*w+3], q_bytes[4*w+2], q_bytes[4*w+1], q_bytes[4*w]};
        end
        chk("done_pulse", ld_done, 1'b1);
        chk("done_busy", ld_busy, 1'b1);
        chk("done_ready", ld_ready, 1'b0);
        memif_addr = '0;
        tick();
        chk("post_done", ld_done, 1'b0);
        chk("post_busy", ld_busy, 1'b0);
        chk("post_err", ld_err, 1'b0);
        chk("post_word0", memif_data, mem_model[0]);
        q_pat.delete();
    endtask

    initial begin
        logic [31:2] a;
        int n;
        reset = 1'b1; ld_start = 1'b0; ld_count = '0; ld_valid = 1'b0; ld_byte = '0;
        memif_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        chk_idle("reset");

        // Two-word load with fixed bytes and ld_valid held high.
        q_bytes = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        for (int i = 0; i < 8; i++) q_pat.push_back(1'b1);
        load(2);
        memif_addr = 30'd0;
        tick();
        chk("fixed_w0", memif_data, 32'h00A0_0513);
        memif_addr = 30'd1;
        tick();
        chk("fixed_w1", memif_data, 32'h0010_0593);

        // Out-of-range fetch addresses.
        a = '0;
        a[12] = 1'b1;
        rd("oor_bit12", a);
        for (int i = 0; i < 4; i++) begin
            a = 30'($urandom);
            a[31] = 1'b1;
            rd("oor_rand", a);
        end

        // Illegal counts set ld_err without starting a load; a legal start clears it.
        ld_start = 1'b1; ld_count = '0;
        tick();
        ld_start = 1'b0;
        chk("cnt0_err", ld_err, 1'b1);
        chk("cnt0_busy", ld_busy, 1'b0);
        ld_start = 1'b1; ld_count = CW'(DEPTH + 1);
        tick();
        ld_start = 1'b0;
        chk("cntbig_err", ld_err, 1'b1);
        chk("cntbig_busy", ld_busy, 1'b0);
        fill_bytes(1);
        load(1);

        // Stalled one-word load.
        fill_bytes(1);
        q_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        load(1);
        rd("stall_w0", 30'd0);

        // Random short loads with random read-back.
        for (int t = 0; t < 5; t++) begin
            n = $urandom_range(8, 1);
            fill_bytes(n);
            load(n);
            for (int i = 0; i < 6; i++) rd("rand_rd", 30'($urandom_range(n - 1)));
        end

        // Full-depth load, then a one-word reload only touches word 0.
        fill_bytes(DEPTH);
        load(DEPTH);
        for (int i = 0; i < 24; i++) rd("full_rd", 30'($urandom_range(DEPTH - 1)));
        rd("full_last", 30'(DEPTH - 1));
        fill_bytes(1);
        load(1);
        rd("reload_w0", 30'd0);
        rd("reload_w1", 30'd1);
        rd("reload_last", 30'(DEPTH - 1));

        // Reset clears a sticky ld_err.
        ld_start = 1'b1; ld_count = '0;
        tick();
        ld_start = 1'b0;
        chk("err_set", ld_err, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("err_reset", ld_err, 1'b0);

        // Reset in the middle of a three-word load after six bytes.
        fill_bytes(3);
        ld_start = 1'b1; ld_count = CW'(3);
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_byte = q_bytes[i];
            tick();
        end
        ld_valid = 1'b0;
        tick();
        ld_valid = 1'b1;
        for (int i = 4; i < 6; i++) begin
            ld_byte = q_bytes[i];
            tick();
        end
        reset = 1'b1;
        ld_byte = q_bytes[6];
        tick();
        reset = 1'b0;
        ld_valid = 1'b0;
        chk_idle("midrst");
        mem_model[0] = {q_bytes[3], q_bytes[2], q_bytes[1], q_bytes[0]};
        rd("midrst_w0", 30'd0);
        rd("midrst_w1", 30'd1);

        // Reset wins over a simultaneous start; a start right after reset is taken.
        reset = 1'b1; ld_start = 1'b1; ld_count = CW'(1);
        tick();
        reset = 1'b0;
        chk("rstprio_busy", ld_busy, 1'b0);
        chk("rstprio_data", memif_data, NOP);
        fill_bytes(1);
        load(1);
        rd("after_rst_w0", 30'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
